dmem_pipe: RTL

Parametrised successor of the single-cycle data memory. Word-organised data RAM for the xgriscv core, with a valid/ready request channel and an in-order response channel. Read latency is configurable and responses support backpressure. The block does its own byte-lane store steering, load sign/zero extension and misalignment detection, so the core's MEM stage passes the raw address, size and store data.

---
 rtl/dmem_pipe_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_pipe.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmem_pipe_pkg.sv
// rtl/dmem_pipe_pkg.sv - shared size codes, pipeline stage type and lane helper for dmem_pipe
package dmem_pipe_pkg;

    localparam logic [1:0] DMEM_SZ_B = 2'b00;
    localparam logic [1:0] DMEM_SZ_H = 2'b01;
    localparam logic [1:0] DMEM_SZ_W = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } dmem_stage_t;

    // Expand a 4-bit byte-enable into a 32-bit bit mask for the read-modify-write merge.
    function automatic logic [31:0] dmem_be_to_bits(input logic [3:0] be);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{be[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane steering, load extraction/extension and misalignment detection
module dmem_lane_align
    import dmem_pipe_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext,
    output logic        misalign_err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = raw_word[{addr_lo, 3'b000} +: 8];
    assign sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        byte_mask     = 4'b0000;
        wdata_steered = wdata;
        rdata_ext     = '0;
        misalign_err  = 1'b0;
        case (size)
            DMEM_SZ_B: begin
                byte_mask     = 4'b0001 << addr_lo;
                wdata_steered = {4{wdata[7:0]}};
                rdata_ext     = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            end
            DMEM_SZ_H: begin
                misalign_err  = addr_lo[0];
                byte_mask     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_steered = {2{wdata[15:0]}};
                rdata_ext     = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            end
            DMEM_SZ_W: begin
                misalign_err = (addr_lo != 2'b00);
                byte_mask    = 4'b1111;
                rdata_ext    = raw_word;
            end
            default: misalign_err = 1'b1;
        endcase
        // A faulting access must neither write nor return data.
        if (misalign_err) begin
            byte_mask = 4'b0000;
            rdata_ext = '0;
        end
    end

endmodule

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - word RAM with valid/ready requests and RD_LATENCY response pipe; DMEM_TRACE_EN adds store/error trace
module dmem_pipe
    import dmem_pipe_pkg::*;
#(
    parameter int    XLEN        = 32,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    RD_LATENCY  = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    dmem_stage_t stage_q [RD_LATENCY];
    dmem_stage_t stage_d;

    logic             advance;
    logic             accept;
    logic             store_en;
    logic [IDX_W-1:0] word_idx;
    logic [XLEN-1:0]  raw_word;
    logic [XLEN-1:0]  merged_word;
    logic [XLEN-1:0]  lane_bits;
    logic [3:0]       byte_mask;
    logic [XLEN-1:0]  wdata_steered;
    logic [XLEN-1:0]  rdata_ext;
    logic             misalign_err;
    logic             unused_addr_hi;

    // The pipe only stops when the head response is being held back by the consumer.
    assign advance   = !(rsp_valid && !rsp_ready);
    assign req_ready = advance && !reset;
    assign accept    = req_valid && req_ready;

    assign word_idx       = req_addr[IDX_W+1:2];
    assign raw_word       = mem[word_idx];
    assign unused_addr_hi = ^req_addr[XLEN-1:IDX_W+2];

    dmem_lane_align u_lane_align (
        .addr_lo       (req_addr[1:0]),
        .size          (req_size),
        .is_unsigned   (req_unsigned),
        .wdata         (req_wdata),
        .raw_word      (raw_word),
        .byte_mask     (byte_mask),
        .wdata_steered (wdata_steered),
        .rdata_ext     (rdata_ext),
        .misalign_err  (misalign_err)
    );

    assign lane_bits   = dmem_be_to_bits(byte_mask);
    assign merged_word = (raw_word & ~lane_bits) | (wdata_steered & lane_bits);
    assign store_en    = accept && req_we && !misalign_err;

    always_comb begin
        stage_d       = '0;
        stage_d.valid = accept;
        stage_d.err   = accept && misalign_err;
        stage_d.rdata = (accept && !req_we) ? rdata_ext : '0;
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[word_idx] <= merged_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance) begin
            stage_q[0] <= stage_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign rsp_valid = stage_q[RD_LATENCY-1].valid;
    assign rsp_err   = stage_q[RD_LATENCY-1].err;
    assign rsp_rdata = stage_q[RD_LATENCY-1].rdata;

`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (store_en) begin
            $display("dataaddr = %h, writedata = %h", {req_addr[XLEN-1:2], 2'b00}, merged_word);
        end
        if (accept && misalign_err) begin
            $display("dmem err addr = %h", req_addr);
        end
    end
`else
`endif

endmodule
